mem_display_sequencer: RTL and testbench

MEM_DISPLAY_SEQUENCER -- requirements
Module: mem_display_sequencer

---
 rtl/mem_display_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mem_display_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_display_sequencer.sv
// mem_display_sequencer
// Walks a block of data memory word by word and hands the low 16 bits of
// each word to a 4-digit display scanner. Each word occupies the display for
// DWELL cycles of clk_1k. The walk (re)starts on every synchronized rising
// edge of the board's finish level.
// Optional feature macro: MANUAL_STEP_EN. When it is defined, a debounced
// btn_next press advances to the next word early while a word is on show.
module mem_display_sequencer #(
  parameter logic [31:0] START_ADDR = 32'h0000_0004,
  parameter int          WORD_COUNT = 16,
  parameter int          DWELL      = 1000,
  parameter int          DEBOUNCE   = 20
) (
  input  logic        clk_1k,
  input  logic        reset,
  input  logic        finish,
  input  logic        btn_next,
  input  logic [31:0] mem_rd_data,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  output logic [15:0] digits,
  output logic        disp_valid,
  output logic [15:0] word_index,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, CAPTURE, SHOW} state_t;

  localparam logic [15:0] LAST_IDX   = 16'(WORD_COUNT - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

  state_t      state_q;
  logic        rd_en_q;
  logic [31:0] addr_q;
  logic [15:0] digits_q;
  logic        valid_q;
  logic [15:0] idx_q;
  logic        busy_q;
  logic [15:0] dwell_q;

  logic        fin_s1_q, fin_s2_q, fin_s3_q;
  logic        restart;
  logic        step;
  logic        advance;
  logic        wrap;
  logic [15:0] idx_d;
  logic [31:0] addr_d;

  // Only the low half of the memory word is displayed.
  logic unused_hi;
  assign unused_hi = ^mem_rd_data[31:16];

  // finish is asynchronous: two flops resolve metastability, the third keeps
  // the previous synchronized level so a held-high finish restarts only once.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      fin_s1_q <= 1'b0;
      fin_s2_q <= 1'b0;
      fin_s3_q <= 1'b0;
    end else begin
      fin_s1_q <= finish;
      fin_s2_q <= fin_s1_q;
      fin_s3_q <= fin_s2_q;
    end
  end

  assign restart = fin_s2_q & ~fin_s3_q;

`ifdef MANUAL_STEP_EN
  logic        btn_s1_q, btn_s2_q, btn_db_q, btn_rise_q;
  logic [15:0] db_cnt_q;
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE - 1);

  // Button debounce: the synchronized level must differ from the accepted
  // level for DEBOUNCE consecutive cycles before it is accepted; an accepted
  // rise produces a one-cycle step pulse.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_db_q   <= 1'b0;
      btn_rise_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      btn_s1_q   <= btn_next;
      btn_s2_q   <= btn_s1_q;
      btn_rise_q <= 1'b0;
      if (btn_s2_q == btn_db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        btn_db_q   <= btn_s2_q;
        btn_rise_q <= btn_s2_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 16'd1;
      end
    end
  end

  assign step = btn_rise_q;
`else
  logic unused_btn;
  assign unused_btn = btn_next;
  assign step       = 1'b0;
`endif

  // Next word position; the last word wraps back to the start of the block.
  // Address arithmetic is naturally modulo 2^32.
  assign wrap    = (idx_q == LAST_IDX);
  assign idx_d   = wrap ? 16'd0 : idx_q + 16'd1;
  assign addr_d  = wrap ? START_ADDR : addr_q + 32'd4;
  // A button step and a dwell expiry in the same cycle are one advance.
  assign advance = (state_q == SHOW) && ((dwell_q == DWELL_LAST) || step);

  // Sequencer FSM with registered outputs. A restart outranks everything,
  // including an advance due in the same cycle.
  always_ff @(posedge clk_1k or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_en_q  <= 1'b0;
      addr_q   <= START_ADDR;
      digits_q <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      dwell_q  <= '0;
    end else if (restart) begin
      state_q <= FETCH;
      rd_en_q <= 1'b1;
      addr_q  <= START_ADDR;
      idx_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        FETCH: begin
          // Address has been on the port for a cycle; hold it one more.
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          digits_q <= mem_rd_data[15:0];
          valid_q  <= 1'b1;
          dwell_q  <= '0;
          rd_en_q  <= 1'b0;
          state_q  <= SHOW;
        end
        SHOW: begin
          if (advance) begin
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            rd_en_q <= 1'b1;
            state_q <= FETCH;
          end else begin
            dwell_q <= dwell_q + 16'd1;
          end
        end
        default: begin
          // IDLE: wait for a restart; the CPU owns the memory port.
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign digits     = digits_q;
  assign disp_valid = valid_q;
  assign word_index = idx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_mem_display_sequencer.sv
// Directed bench for mem_display_sequencer (DWELL small, WORD_COUNT=3).
module tb_mem_display_sequencer;

`ifdef MANUAL_STEP_EN
  localparam int DW = 30;
`else
  localparam int DW = 5;
`endif
  localparam int P  = DW + 2;

  logic        clk_1k = 1'b0;
  logic        reset, finish, btn_next;
  logic [31:0] mem_rd_data;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [15:0] digits;
  logic        disp_valid;
  logic [15:0] word_index;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fetch_cnt = 0;
  logic prev_en = 1'b0;

  mem_display_sequencer #(
    .START_ADDR(32'h0000_0004), .WORD_COUNT(3), .DWELL(DW), .DEBOUNCE(4)
  ) dut (
    .clk_1k(clk_1k), .reset(reset), .finish(finish), .btn_next(btn_next),
    .mem_rd_data(mem_rd_data), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .digits(digits), .disp_valid(disp_valid), .word_index(word_index),
    .busy(busy)
  );

  always #5 clk_1k = ~clk_1k;

  // Combinational data memory.
  always_comb begin
    case (mem_addr)
      32'h4:   mem_rd_data = 32'h0000_1234;
      32'h8:   mem_rd_data = 32'hABCD_5678;
      32'hC:   mem_rd_data = 32'h0000_9ABC;
      default: mem_rd_data = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock edge; sample 1ns later and count FETCH entries (rd_en rises).
  task automatic tick();
    @(posedge clk_1k);
    #1;
    cyc++;
    if (mem_rd_en && !prev_en) fetch_cnt++;
    prev_en = mem_rd_en;
  endtask

  task automatic tick_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic wait_fetch(input logic [15:0] idx, output int at);
    int c0;
    logic found;
    found = 1'b0;
    at = cyc;
    for (int i = 0; i < 200 && !found; i++) begin
      c0 = fetch_cnt;
      tick();
      if (fetch_cnt != c0 && word_index == idx) begin
        found = 1'b1;
        at = cyc;
      end
    end
    chk("wait_fetch", {15'd0, found, word_index}, {15'd0, 1'b1, idx});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n0, f, cnt0, expc;
    reset = 1'b1; finish = 1'b0; btn_next = 1'b0;
    tick(); tick();
    chk("rst_busy",  busy, 0);
    chk("rst_rden",  mem_rd_en, 0);
    chk("rst_addr",  mem_addr, 32'h4);
    chk("rst_dig",   digits, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_idx",   word_index, 0);
    #2 reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_busy", busy, 0);

    // First restart and latency.
    finish = 1'b1;
    tick(); n0 = cyc;                  // edge N samples finish
    tick(); chk("n1_busy", busy, 0);
    tick();
    chk("n2_rden", mem_rd_en, 1);
    chk("n2_addr", mem_addr, 32'h4);
    chk("n2_busy", busy, 1);
    chk("n2_dig",  digits, 0);
    tick();
    chk("n3_rden", mem_rd_en, 1);
    chk("n3_dig",  digits, 0);
    tick();
    chk("n4_dig",   digits, 16'h1234);
    chk("n4_valid", disp_valid, 1);
    chk("n4_rden",  mem_rd_en, 0);

    // Word sequence and exact per-word period, finish still held high.
    for (int k = 1; k <= 3; k++) begin
      tick_to(n0 + 2 + k*P - 1);
      chk("seq_pre_rden", mem_rd_en, 0);
      tick();
      chk("seq_rden", mem_rd_en, 1);
      chk("seq_addr", mem_addr, 32'h4 + 32'(4 * (k % 3)));
      chk("seq_idx",  word_index, 16'(k % 3));
      tick(); tick();
      chk("seq_dig", digits, (k % 3 == 1) ? 16'h5678 : (k % 3 == 2) ? 16'h9ABC : 16'h1234);
    end

    // finish held ~100 cycles: only dwell advances after the single restart.
    tick_to(n0 + 99);
    expc = (97 / P) + 1;
    chk("held_fetches", fetch_cnt, expc);
    chk("held_addr", mem_addr, 32'h4 + 32'(4 * ((expc - 1) % 3)));
    finish = 1'b0;
    repeat (6) tick();

    // Restart landing on word 0's dwell expiry wins over the advance.
    wait_fetch(16'd0, f);
    tick_to(f + P - 3);
    finish = 1'b1;
    tick_to(f + P);
    chk("prio0_addr", mem_addr, 32'h4);
    chk("prio0_idx",  word_index, 0);
    chk("prio0_rden", mem_rd_en, 1);
    tick_to(f + 2*P);
    chk("prio0_next_addr", mem_addr, 32'h8);
    chk("prio0_next_idx",  word_index, 1);
    finish = 1'b0;
    repeat (6) tick();

    // Restart landing on word 2's dwell expiry.
    wait_fetch(16'd2, f);
    tick_to(f + P - 3);
    finish = 1'b1;
    tick_to(f + P);
    chk("prio2_addr", mem_addr, 32'h4);
    chk("prio2_idx",  word_index, 0);
    tick_to(f + P + 2);
    chk("prio2_dig", digits, 16'h1234);
    finish = 1'b0;
    repeat (6) tick();

    // Reset asserted in CAPTURE abandons the read.
    wait_fetch(16'd1, f);
    tick();                             // now in CAPTURE
    #2 reset = 1'b1;
    #1;
    chk("rc_busy",  busy, 0);
    chk("rc_rden",  mem_rd_en, 0);
    chk("rc_dig",   digits, 0);
    chk("rc_valid", disp_valid, 0);
    chk("rc_addr",  mem_addr, 32'h4);
    chk("rc_idx",   word_index, 0);
    #2 reset = 1'b0;
    repeat (6) tick();
    chk("rc_post_dig",  digits, 0);
    chk("rc_post_busy", busy, 0);

    // A fresh finish edge restarts after the reset.
    finish = 1'b1;
    tick(); n0 = cyc;
    tick_to(n0 + 4);
    chk("rs_dig",   digits, 16'h1234);
    chk("rs_valid", disp_valid, 1);
    finish = 1'b0;
    repeat (6) tick();

`ifdef MANUAL_STEP_EN
    // Bouncing button never advances; a 4-cycle press advances once.
    wait_fetch(16'd0, f);
    tick_to(f + 2);
    cnt0 = fetch_cnt;
    for (int i = 0; i < 3; i++) begin
      btn_next = 1'b1; tick(); tick();
      btn_next = 1'b0; tick(); tick();
    end
    chk("btn_bounce", fetch_cnt, cnt0);
    btn_next = 1'b1;
    repeat (4) tick();
    btn_next = 1'b0;
    repeat (6) tick();
    chk("btn_press_cnt", fetch_cnt, cnt0 + 1);
    chk("btn_press_idx", word_index, 1);
`else
    cnt0 = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
